tick_slot_scheduler: RTL and testbench

Time-slot scheduler built on the 1 kHz divided clock. It divides the system clock down to a base tick. On every tick it hands a one-hot grant to the next requester in round-robin order, so N consumers share one slow time base (e.g. display digit multiplexing, periodic sampling). It also drives the divided square wave clkout for legacy consumers of the divider.

---
 rtl/tick_sched_pkg.sv | 41 ++++
 rtl/tick_prescaler.sv | 39 +++
 rtl/tick_slot_scheduler.sv | 61 ++++++
 tb/tb_tick_slot_scheduler.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// Shared types and helpers for the tick-driven round-robin slot scheduler.
package tick_sched_pkg;

   localparam int unsigned MAX_N = 32;
   localparam int unsigned IDX_W = 5;

   typedef enum logic {S_IDLE, S_SERVE} state_t;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } pick_t;

   function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
      return clk_hz / tick_hz;
   endfunction

   function automatic int unsigned calc_sw(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Search last+1, last+2, ..., last (mod n); the first set request wins.
   function automatic pick_t rr_pick(input logic [MAX_N-1:0] req, input int unsigned n,
                                     input int unsigned last);
      pick_t       p;
      int unsigned i;
      p = '0;
      for (int unsigned k = 1; k <= MAX_N; k++) begin
         if (k <= n && !p.found) begin
            i = last + k;
            if (i >= n) i = i - n;
            if (req[i[IDX_W-1:0]]) begin
               p.found = 1'b1;
               p.idx   = i[IDX_W-1:0];
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by DIV: one-cycle tick pulse plus a 50% duty clkout square wave.
module tick_prescaler #(
   parameter int unsigned DIV = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick,
   output logic clkout,
   output logic tick_edge_c
);

   localparam int unsigned CW = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

   if (DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
      $fatal(1, "tick_prescaler: DIV must be even and >= 2");
   end

   logic [CW-1:0] cnt;

   assign tick_edge_c = en && (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         tick   <= 1'b0;
         clkout <= 1'b0;
      end else begin
         tick <= tick_edge_c;
         if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
            if (cnt == HALF || cnt == LAST) clkout <= ~clkout;
         end
      end
   end

endmodule

// File: rtl/tick_slot_scheduler.sv
// Round-robin time-slot scheduler: re-arbitrates requesters once per prescaler tick.
module tick_slot_scheduler
   import tick_sched_pkg::*;
#(
   parameter  int unsigned CLK_HZ  = 100_000_000,
   parameter  int unsigned TICK_HZ = 1000,
   parameter  int unsigned N       = 4,
   localparam int unsigned DIV     = calc_div(CLK_HZ, TICK_HZ),
   localparam int unsigned SW      = calc_sw(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  grant,
   output logic [SW-1:0] slot,
   output logic          tick,
   output logic          clkout,
   output logic          active
);

   if (DIV < 2 || (DIV % 2) != 0 || N < 1 || N > MAX_N) begin : g_bad_cfg
      $fatal(1, "tick_slot_scheduler: invalid DIV or N");
   end

   state_t state;
   logic   tick_edge_c;
   pick_t  pick_c;

   tick_prescaler #(.DIV(DIV)) u_prescaler (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .tick        (tick),
      .clkout      (clkout),
      .tick_edge_c (tick_edge_c)
   );

   always_comb pick_c = rr_pick(MAX_N'(req), N, 32'(slot));

   assign active = (state == S_SERVE);

   // Grant, slot and state only move on tick edges, so each grant lasts a full period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         grant <= '0;
         slot  <= SW'(N - 1);
      end else if (tick_edge_c) begin
         if (pick_c.found) begin
            state <= S_SERVE;
            grant <= N'(1) << pick_c.idx;
            slot  <= SW'(pick_c.idx);
         end else begin
            state <= S_IDLE;
            grant <= '0;
         end
      end
   end

endmodule

// File: tb/tb_tick_slot_scheduler.sv
// Directed bench for tick_slot_scheduler with DIV=10, N=4 and a 10 ns clock.
module tb_tick_slot_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] slot;
   logic       tick;
   logic       clkout;
   logic       active;

   int checks = 0;
   int errors = 0;

   tick_slot_scheduler #(.CLK_HZ(20), .TICK_HZ(2), .N(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .req    (req),
      .grant  (grant),
      .slot   (slot),
      .tick   (tick),
      .clkout (clkout),
      .active (active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      en    = 1'b0;
      req   = 4'b0000;
      #1;
      chk("rst_grant",  32'(grant),  32'h0);
      chk("rst_active", 32'(active), 32'h0);
      chk("rst_slot",   32'(slot),   32'h3);
      chk("rst_tick",   32'(tick),   32'h0);
      chk("rst_clkout", 32'(clkout), 32'h0);
      #2;
      reset = 1'b0;
      en    = 1'b1;

      // 1: idle divider timing
      step(4);  chk("e4_clkout", 32'(clkout), 32'h0);
      step(1);  chk("e5_clkout", 32'(clkout), 32'h1);
                chk("e5_tick",   32'(tick),   32'h0);
      step(4);  chk("e9_clkout", 32'(clkout), 32'h1);
                chk("e9_tick",   32'(tick),   32'h0);
      step(1);  chk("e10_clkout", 32'(clkout), 32'h0);
                chk("e10_tick",   32'(tick),   32'h1);
                chk("e10_grant",  32'(grant),  32'h0);
                chk("e10_active", 32'(active), 32'h0);
                chk("e10_slot",   32'(slot),   32'h3);
      step(1);  chk("e11_tick",   32'(tick),   32'h0);

      // 2: round robin over 1011
      req = 4'b1011;
      step(8);  chk("e19_grant", 32'(grant), 32'h0);
                chk("e19_tick",  32'(tick),  32'h0);
      step(1);  chk("e20_grant",  32'(grant),  32'h1);
                chk("e20_slot",   32'(slot),   32'h0);
                chk("e20_active", 32'(active), 32'h1);
                chk("e20_tick",   32'(tick),   32'h1);
      step(10); chk("e30_grant", 32'(grant), 32'h2);
                chk("e30_slot",  32'(slot),  32'h1);
      step(10); chk("e40_grant", 32'(grant), 32'h8);
                chk("e40_slot",  32'(slot),  32'h3);
      step(5);  chk("e45_grant", 32'(grant), 32'h8);
                chk("e45_tick",  32'(tick),  32'h0);
      step(5);  chk("e50_grant", 32'(grant), 32'h1);
                chk("e50_slot",  32'(slot),  32'h0);
                chk("e50_tick",  32'(tick),  32'h1);

      // 3: single requester re-granted each tick
      req = 4'b0100;
      step(10); chk("e60_grant", 32'(grant), 32'h4);
                chk("e60_slot",  32'(slot),  32'h2);
      step(5);  chk("e65_grant", 32'(grant), 32'h4);
      step(5);  chk("e70_grant", 32'(grant), 32'h4);
                chk("e70_slot",  32'(slot),  32'h2);
                chk("e70_tick",  32'(tick),  32'h1);

      // 4: request dropped mid-period
      req = 4'b0010;
      step(10); chk("e80_grant", 32'(grant), 32'h2);
                chk("e80_slot",  32'(slot),  32'h1);
      step(3);  req = 4'b0000;
      step(6);  chk("e89_grant",  32'(grant),  32'h2);
                chk("e89_active", 32'(active), 32'h1);
      step(1);  chk("e90_grant",  32'(grant),  32'h0);
                chk("e90_active", 32'(active), 32'h0);
                chk("e90_slot",   32'(slot),   32'h1);
                chk("e90_tick",   32'(tick),   32'h1);

      // 5: enable dropped for 7 cycles at cnt=4
      req = 4'b1000;
      step(10); chk("e100_grant",  32'(grant),  32'h8);
                chk("e100_slot",   32'(slot),   32'h3);
                chk("e100_active", 32'(active), 32'h1);
      step(4);  chk("e104_clkout", 32'(clkout), 32'h0);
      en  = 1'b0;
      req = 4'b0110;
      for (int k = 0; k < 7; k++) begin
         step(1);
         chk("frz_tick",   32'(tick),   32'h0);
         chk("frz_clkout", 32'(clkout), 32'h0);
         chk("frz_grant",  32'(grant),  32'h8);
         chk("frz_slot",   32'(slot),   32'h3);
      end
      en = 1'b1;
      step(1);  chk("e112_clkout", 32'(clkout), 32'h1);
                chk("e112_tick",   32'(tick),   32'h0);
      step(4);  chk("e116_tick",   32'(tick),   32'h0);
                chk("e116_grant",  32'(grant),  32'h8);
      step(1);  chk("e117_tick",   32'(tick),   32'h1);
                chk("e117_grant",  32'(grant),  32'h2);
                chk("e117_slot",   32'(slot),   32'h1);
                chk("e117_clkout", 32'(clkout), 32'h0);

      // 6: asynchronous reset while serving
      step(5);  chk("e122_clkout", 32'(clkout), 32'h1);
                chk("e122_grant",  32'(grant),  32'h2);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_grant",  32'(grant),  32'h0);
      chk("arst_active", 32'(active), 32'h0);
      chk("arst_tick",   32'(tick),   32'h0);
      chk("arst_clkout", 32'(clkout), 32'h0);
      chk("arst_slot",   32'(slot),   32'h3);
      req = 4'b1100;
      step(1);  chk("e123_grant", 32'(grant), 32'h0);
                chk("e123_slot",  32'(slot),  32'h3);
      reset = 1'b0;
      step(9);  chk("r9_tick",  32'(tick),  32'h0);
                chk("r9_grant", 32'(grant), 32'h0);
      step(1);  chk("r10_tick",   32'(tick),   32'h1);
                chk("r10_grant",  32'(grant),  32'h4);
                chk("r10_slot",   32'(slot),   32'h2);
                chk("r10_active", 32'(active), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
